// File: rtl/patch_fetch_ctrl_if.sv
// Read-request bus between the patch fetch sequencer and the activation cache.
interface patch_fetch_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 21
) ();
    logic                  request;
    logic                  read_write;
    logic [ADDR_WIDTH-1:0] address;
    logic                  valid;
    logic                  error;

    modport master (
        output request, read_write, address,
        input  valid, error
    );

    modport slave (
        input  request, read_write, address,
        output valid, error
    );
endinterface

// File: rtl/patch_fetch_ctrl.sv
// Fetches M activations from the cache into activation_cache slots 0..M-1
// and flags completion, cache error or response timeout.
module patch_fetch_ctrl #(
    parameter int unsigned M           = 16,
    parameter int unsigned ADDR_WIDTH  = 21,
    parameter int unsigned ADDR_STRIDE = 1,
    parameter int unsigned TIMEOUT     = 255,
    localparam int unsigned IDX_W      = $clog2(M),
    localparam int unsigned TMO_W      = $clog2(TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_address,
    patch_fetch_ctrl_if.master    cache,
    output logic                  store_enable,
    output logic [IDX_W-1:0]      index,
    output logic                  busy,
    output logic                  done,
    output logic                  patch_ready,
    output logic                  fetch_error
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic                  request_q, request_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  patch_ready_q, patch_ready_d;
    logic                  fetch_error_q, fetch_error_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            tmo_q         <= '0;
            address_q     <= '0;
            request_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            patch_ready_q <= 1'b0;
            fetch_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            tmo_q         <= tmo_d;
            address_q     <= address_d;
            request_q     <= request_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            patch_ready_q <= patch_ready_d;
            fetch_error_q <= fetch_error_d;
        end
    end

    // store_enable must be combinational: the cache slot samples activation_out on the valid edge.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        tmo_d         = tmo_q;
        address_d     = address_q;
        patch_ready_d = patch_ready_q;
        fetch_error_d = fetch_error_q;
        store_enable  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = ISSUE;
                    address_d     = base_address;
                    idx_d         = '0;
                    tmo_d         = '0;
                    patch_ready_d = 1'b0;
                    fetch_error_d = 1'b0;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (cache.error) begin
                    state_d = ERR;
                end else if (cache.valid) begin
                    store_enable = 1'b1;
                    if (idx_q == IDX_W'(M - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d   = ISSUE;
                        idx_d     = idx_q + IDX_W'(1);
                        tmo_d     = '0;
                        address_d = address_q + ADDR_WIDTH'(ADDR_STRIDE);
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            DONE: begin
                patch_ready_d = 1'b1;
                state_d       = IDLE;
            end
            ERR: begin
                fetch_error_d = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Registered strobes track the state being entered.
        request_d = (state_d == ISSUE);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    assign cache.request    = request_q;
    assign cache.read_write = 1'b1;
    assign cache.address    = address_q;
    assign index            = idx_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign patch_ready      = patch_ready_q;
    assign fetch_error      = fetch_error_q;

endmodule

// File: tb/tb_patch_fetch_ctrl.sv
// Randomized directed bench for patch_fetch_ctrl with a cache responder and timeline model.
module tb_patch_fetch_ctrl;
    localparam int unsigned M      = 16;
    localparam int unsigned AW     = 21;
    localparam int unsigned STRIDE = 1;
    localparam int unsigned TMO    = 8;
    localparam int unsigned IW     = $clog2(M);
    localparam logic [31:0] MARK   = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_address;
    logic          store_enable;
    logic [IW-1:0] index;
    logic          busy, done, patch_ready, fetch_error;

    patch_fetch_ctrl_if #(.ADDR_WIDTH(AW)) cache_if ();

    patch_fetch_ctrl #(
        .M(M), .ADDR_WIDTH(AW), .ADDR_STRIDE(STRIDE), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_address(base_address),
        .cache(cache_if), .store_enable(store_enable), .index(index), .busy(busy),
        .done(done), .patch_ready(patch_ready), .fetch_error(fetch_error)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            seq_start = 0;
    logic [31:0]   mem [M];
    int            lat [M];
    int            req_cyc [$];
    logic [AW-1:0] req_addr [$];
    int            st_cyc [$];
    int            st_idx [$];
    int            done_cyc [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] act_data(input logic [AW-1:0] a);
        return 32'(a) ^ 32'h5EED_0000;
    endfunction

    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int k);
        return AW'(32'(base) + 32'(k) * STRIDE);
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_request"}, cache_if.request, 0);
        chk({tag, "_read_write"}, cache_if.read_write, 1);
        chk({tag, "_address"}, cache_if.address, 0);
        chk({tag, "_store_enable"}, store_enable, 0);
        chk({tag, "_index"}, index, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_patch_ready"}, patch_ready, 0);
        chk({tag, "_fetch_error"}, fetch_error, 0);
    endtask

    // Starts a sequence in the current (idle) cycle, plays the cache, then checks the timeline.
    task automatic run_seq(input logic [AW-1:0] base, input int fixed_lat, input int err_idx,
                           input int drop_idx, input bit extra, input int reset_at);
        int s, cur, resp_at, idle_cyc, n_req_exp, n_st_exp, rk, last_rk, idle_exp;
        bit ok, ended;
        logic [31:0] cur_data;

        for (int k = 0; k < int'(M); k++) begin
            if (fixed_lat > 0) lat[k] = fixed_lat;
            else if ($urandom_range(0, 3) == 0) lat[k] = int'($urandom_range(1, TMO));
            else lat[k] = int'($urandom_range(1, 3));
            mem[k] = MARK;
        end
        req_cyc.delete(); req_addr.delete(); st_cyc.delete(); st_idx.delete(); done_cyc.delete();

        start = 1'b1;
        base_address = base;
        s = cyc;
        seq_start = s;
        cur = -1; resp_at = -1; idle_cyc = -1; ended = 1'b0; cur_data = '0;

        for (int n = 0; n < 4000 && !ended; n++) begin
            tick();
            cache_if.valid = 1'b0;
            cache_if.error = 1'b0;
            start = extra && busy && ($urandom_range(0, 2) == 0);
            if (cyc == s + 1) begin
                chk("clear_patch_ready", patch_ready, 0);
                chk("clear_fetch_error", fetch_error, 0);
            end
            if (cache_if.request) begin
                req_cyc.push_back(cyc);
                req_addr.push_back(cache_if.address);
                cur++;
                resp_at = (cur == drop_idx || cur >= int'(M)) ? -1 : cyc + lat[cur];
            end else if (busy && cur >= 0) begin
                chk("address_hold", cache_if.address, req_addr[$]);
            end
            if (reset_at >= 0 && cur == reset_at && cyc == req_cyc[$] + 1) begin
                reset = 1'b1;
                resp_at = -1;
                ended = 1'b1;
            end else if (cyc == resp_at) begin
                if (cur == err_idx) begin
                    cache_if.error = 1'b1;
                    cache_if.valid = 1'($urandom_range(0, 1));
                end else begin
                    cache_if.valid = 1'b1;
                    cur_data = act_data(req_addr[$]);
                end
            end
            #1;
            if (store_enable) begin
                st_cyc.push_back(cyc);
                st_idx.push_back(int'(index));
                mem[index] = cur_data;
            end
            if (done) done_cyc.push_back(cyc);
            if (!busy) begin
                idle_cyc = cyc;
                ended = 1'b1;
            end
        end
        start = 1'b0;
        cache_if.valid = 1'b0;
        cache_if.error = 1'b0;

        ok = (err_idx < 0 && drop_idx < 0 && reset_at < 0);
        n_req_exp = (reset_at >= 0) ? reset_at + 1 :
                    (err_idx >= 0)  ? err_idx + 1 :
                    (drop_idx >= 0) ? drop_idx + 1 : int'(M);
        n_st_exp = ok ? int'(M) : n_req_exp - 1;

        chk("request_count", req_cyc.size(), n_req_exp);
        chk("store_count", st_cyc.size(), n_st_exp);
        rk = s + 1;
        last_rk = rk;
        for (int k = 0; k < n_req_exp; k++) begin
            last_rk = rk;
            if (k < req_cyc.size()) begin
                chk("request_cycle", req_cyc[k], rk);
                chk("request_address", req_addr[k], exp_addr(base, k));
            end
            if (k < n_st_exp && k < st_cyc.size()) begin
                chk("store_index", st_idx[k], k);
                chk("store_cycle", st_cyc[k], rk + lat[k]);
            end
            rk = rk + lat[k] + 1;
        end

        if (ok) begin
            chk("done_count", done_cyc.size(), 1);
            idle_exp = last_rk + lat[M-1] + 2;
            if (done_cyc.size() > 0) chk("done_cycle", done_cyc[0], last_rk + lat[M-1] + 1);
        end else begin
            chk("no_done", done_cyc.size(), 0);
            idle_exp = (err_idx >= 0) ? last_rk + lat[err_idx] + 2 : last_rk + int'(TMO) + 2;
        end

        if (reset_at < 0) begin
            chk("idle_cycle", idle_cyc, idle_exp);
            chk("patch_ready_end", patch_ready, 32'(ok));
            chk("fetch_error_end", fetch_error, 32'(!ok));
        end else begin
            tick();
            reset = 1'b0;
            #1;
            check_reset_outputs("mid_reset");
        end

        for (int k = 0; k < int'(M); k++)
            chk("slot_data", mem[k], (k < n_st_exp) ? act_data(exp_addr(base, k)) : MARK);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        base_address = '0;
        cache_if.valid = 1'b0;
        cache_if.error = 1'b0;
        repeat (3) tick();
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // Fixed latency 2: done lands 49 cycles after the start cycle.
        run_seq(21'h00100, 2, -1, -1, 1'b0, -1);
        if (done_cyc.size() > 0) chk("done_latency_49", done_cyc[0] - seq_start, 49);

        run_seq(21'(32'h0ABCDE), 0, 5, -1, 1'b0, -1);
        run_seq(21'(32'h012340), 0, -1, 3, 1'b0, -1);
        run_seq(21'($urandom), 0, -1, -1, 1'b0, -1);
        run_seq(21'h1FFFFE, 0, -1, -1, 1'b0, -1);

        run_seq(21'($urandom), 0, -1, -1, 1'b1, 7);
        run_seq(21'($urandom), 0, -1, -1, 1'b1, -1);

        for (int i = 0; i < 4; i++) begin
            int e;
            e = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, M - 1)) : -1;
            run_seq(21'($urandom), 0, e, -1, 1'($urandom_range(0, 1)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
